ecc_read_arbiter: RTL and testbench
===================================

ECC_READ_ARBITER -- requirements
Module: ecc_read_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter CODE_W, default 6, check-code width.
REQ-003 SHALL have parameter N_PORTS, default 4, requester count (2..8).
REQ-004 SHALL have parameter PTR_W, default 2, clog2(N_PORTS).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_vld  in  N_PORTS  per-port request valid.
REQ-008 SHALL have port req_rdy  out  N_PORTS  per-port accept; one-hot or zero.
REQ-009 SHALL have port req_data  in  N_PORTS*DATA_W  packed words, port i at [i*DATA_W +: DATA_W].
REQ-010 SHALL have port req_code  in  N_PORTS*CODE_W  packed codes, same packing.
REQ-011 SHALL have port out_vld  out  1  result valid.
REQ-012 SHALL have port out_rdy  in  1  downstream accept.
REQ-013 SHALL have port out_data  out  DATA_W  corrected word.
REQ-014 SHALL have port out_err  out  1  decoder flagged an error.
REQ-015 SHALL have port out_port  out  PTR_W  source port of result.
REQ-016 SHALL have port err_clr  in  1  synchronous clear of err_cnt.
REQ-017 SHALL have port err_cnt  out  16  errors flagged since reset/clear.

Function
REQ-018 SHALL share one ecc_decoder instance among all ports; only the granted port's data/code reach it.
REQ-019 SHALL operate a two-state FSM: EMPTY (output register free) and FULL (result held).
REQ-020 SHALL grant when state is EMPTY, or FULL with out_rdy=1, and any req_vld=1.
REQ-021 SHALL select the grant round-robin: first requesting port at or after rr_ptr, wrapping N_PORTS-1 -> 0.
REQ-022 SHALL assert req_rdy[g] combinationally in the grant cycle only; transfer = req_vld[g]&req_rdy[g].
REQ-023 SHALL register decoder outputs and g on transfer; out_vld rises next cycle (latency 1).
REQ-024 SHALL set rr_ptr to g+1 (wrap to 0 past N_PORTS-1) on transfer; hold otherwise.
REQ-025 SHALL hold out_* stable while out_vld=1 and out_rdy=0; FULL->EMPTY on out_rdy=1 with no new transfer.
REQ-026 SHALL sustain one result per cycle with out_rdy held 1 (simultaneous drain and load).
REQ-027 SHALL increment err_cnt on each transfer whose decoder error flag is 1, saturating at 16'hFFFF.
REQ-028 SHALL give err_clr priority: clear and concurrent increment -> err_cnt=0.
REQ-029 SHALL ignore req_data/req_code of non-granted ports entirely.

Reset
REQ-030 SHALL, on reset=1 at any time, asynchronously force state EMPTY, out_vld=0, out_data=0, out_err=0, out_port=0, rr_ptr=0, err_cnt=0.
REQ-031 SHALL drive req_rdy=0 while reset=1; a result held mid-operation is discarded.

Configuration
REQ-032 SHALL honour macro ECC_ERR_CNT_EN: defined -> err_cnt per REQ-027/028; undefined -> counter removed, err_cnt tied 0, err_clr ignored.

Structure
REQ-033 SHALL place DATA_W/CODE_W defaults and the FSM state encoding in shared package ecc_pkg.
REQ-034 SHALL implement grant selection in sub-module rr_arbiter (req, ptr -> one-hot grant, index).

Verification
REQ-035 Single port: req_vld=4'b0001, clean codeword for 0x12345678 -> next cycle out_vld=1, out_data=0x12345678, out_err=0, out_port=0.
REQ-036 All ports requesting, out_rdy=1 from reset -> out_port sequence 0,1,2,3,0 on consecutive cycles.
REQ-037 out_rdy=0 three cycles with result held -> out_* unchanged, req_rdy=0, no rr_ptr change; out_rdy=1 -> drain and next grant same cycle.
REQ-038 Single-bit flip in data bit 5 -> out_data corrected, out_err=1, err_cnt 0->1; err_clr with another error same cycle -> err_cnt=0.
REQ-039 reset asserted while FULL -> out_vld=0 immediately; after release, first grant starts at port 0.
REQ-040 Build without ECC_ERR_CNT_EN, inject 5 errors -> err_cnt stays 0, all other outputs identical to build with macro.

Source files
------------

// File: rtl/ecc_pkg.sv
// +-----------------------------------------------------------------------------
// | ecc_pkg
// | Shared widths, FSM encoding and Hamming bit-placement helper.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package ecc_pkg;

   localparam int c_data_w = 32;
   localparam int c_code_w = 6;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Hamming position (1-based) of data bit idx: the idx-th non-power-of-two.
   function automatic int unsigned data_pos(input int unsigned idx);
      int unsigned pos;
      int unsigned n;
      pos = 0;
      n   = 0;
      for (int unsigned k = 1; k < 256; k++) begin
         if ((k & (k - 1)) != 0) begin
            if (n == idx && pos == 0) pos = k;
            n++;
         end
      end
      return pos;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ecc_decoder.sv
// +-----------------------------------------------------------------------------
// | ecc_decoder
// | Single-error-correcting Hamming decoder; any nonzero syndrome flags o_err.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module ecc_decoder
   import ecc_pkg::*;
#(
   parameter int DATA_W = c_data_w,
   parameter int CODE_W = c_code_w
) (
   input  logic [DATA_W-1:0] i_data,
   input  logic [CODE_W-1:0] i_code,
   output logic [DATA_W-1:0] o_data,
   output logic              o_err
);

   logic [CODE_W-1:0] w_contrib [DATA_W];
   logic [CODE_W-1:0] w_syn;
   logic [DATA_W-1:0] w_flip;

   generate
      for (genvar i = 0; i < DATA_W; i++) begin : g_bits
         localparam int unsigned c_pos = data_pos(i);
         assign w_contrib[i] = i_data[i] ? CODE_W'(c_pos) : '0;
         assign w_flip[i]    = (w_syn == CODE_W'(c_pos));
      end
   endgenerate

   always_comb begin
      w_syn = i_code;
      for (int i = 0; i < DATA_W; i++) begin
         w_syn = w_syn ^ w_contrib[i];
      end
   end

   // A syndrome naming a check-bit position leaves the data untouched.
   assign o_data = i_data ^ w_flip;
   assign o_err  = |w_syn;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +-----------------------------------------------------------------------------
// | rr_arbiter
// | Picks the first requester at or after i_ptr, wrapping to port 0.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
   parameter int N_PORTS = 4,
   parameter int PTR_W   = 2
) (
   input  logic [N_PORTS-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [N_PORTS-1:0] o_grant,
   output logic [PTR_W-1:0]   o_idx,
   output logic               o_any
);

   logic [PTR_W:0]   w_sum;
   logic [PTR_W-1:0] w_pos;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_sum   = '0;
      w_pos   = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
         if (w_sum >= (PTR_W+1)'(N_PORTS)) w_sum = w_sum - (PTR_W+1)'(N_PORTS);
         w_pos = w_sum[PTR_W-1:0];
         if (!o_any && i_req[w_pos]) begin
            o_any          = 1'b1;
            o_grant[w_pos] = 1'b1;
            o_idx          = w_pos;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ecc_read_arbiter.sv
// +-----------------------------------------------------------------------------
// | ecc_read_arbiter
// | Round-robin read arbiter feeding one shared ECC decoder into a 1-deep result
// | register. Macro ECC_ERR_CNT_EN enables the saturating error counter.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module ecc_read_arbiter
   import ecc_pkg::*;
#(
   parameter int DATA_W  = c_data_w,
   parameter int CODE_W  = c_code_w,
   parameter int N_PORTS = 4,
   parameter int PTR_W   = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_PORTS-1:0]          req_vld,
   output logic [N_PORTS-1:0]          req_rdy,
   input  logic [N_PORTS*DATA_W-1:0]   req_data,
   input  logic [N_PORTS*CODE_W-1:0]   req_code,
   output logic                        out_vld,
   input  logic                        out_rdy,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_err,
   output logic [PTR_W-1:0]            out_port,
   input  logic                        err_clr,
   output logic [15:0]                 err_cnt
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PTR_W-1:0]    r_rr_ptr;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_err;
   logic [PTR_W-1:0]    r_out_port;

   logic [N_PORTS-1:0]  w_grant;
   logic [PTR_W-1:0]    w_idx;
   logic                w_any;
   logic                w_can_grant;
   logic                w_xfer;
   logic [DATA_W-1:0]   w_sel_data;
   logic [CODE_W-1:0]   w_sel_code;
   logic [DATA_W-1:0]   w_dec_data;
   logic                w_dec_err;

   rr_arbiter #(
      .N_PORTS (N_PORTS),
      .PTR_W   (PTR_W)
   ) u_arb (
      .i_req   (req_vld),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_can_grant = ((r_state == ST_EMPTY) || out_rdy) && !reset;
   assign req_rdy     = w_grant & {N_PORTS{w_can_grant}};
   assign w_xfer      = w_any && w_can_grant;

   // Grant-gated OR mux: non-granted ports contribute nothing to the decoder.
   always_comb begin
      w_sel_data = '0;
      w_sel_code = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         w_sel_data = w_sel_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}});
         w_sel_code = w_sel_code | (req_code[i*CODE_W +: CODE_W] & {CODE_W{w_grant[i]}});
      end
   end

   ecc_decoder #(
      .DATA_W (DATA_W),
      .CODE_W (CODE_W)
   ) u_dec (
      .i_data (w_sel_data),
      .i_code (w_sel_code),
      .o_data (w_dec_data),
      .o_err  (w_dec_err)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_EMPTY;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
         ST_FULL:  if (out_rdy && !w_xfer) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_ptr   <= '0;
         r_out_data <= '0;
         r_out_err  <= 1'b0;
         r_out_port <= '0;
      end else if (w_xfer) begin
         r_rr_ptr   <= (w_idx == PTR_W'(N_PORTS - 1)) ? '0 : w_idx + PTR_W'(1);
         r_out_data <= w_dec_data;
         r_out_err  <= w_dec_err;
         r_out_port <= w_idx;
      end
   end

   assign out_vld  = (r_state == ST_FULL);
   assign out_data = r_out_data;
   assign out_err  = r_out_err;
   assign out_port = r_out_port;

`ifdef ECC_ERR_CNT_EN
   logic [15:0] r_err_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                         r_err_cnt <= '0;
      else if (err_clr)                                  r_err_cnt <= '0;
      else if (w_xfer && w_dec_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
   end

   assign err_cnt = r_err_cnt;
`else
   logic w_unused_err_clr;
   assign w_unused_err_clr = err_clr;
   assign err_cnt          = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ecc_read_arbiter.sv
// +-----------------------------------------------------------------------------
// | tb_ecc_read_arbiter
// | Directed scenarios for the ECC read arbiter, one task per scenario.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_ecc_read_arbiter;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    req_vld;
   logic [3:0]    req_rdy;
   logic [127:0]  req_data;
   logic [23:0]   req_code;
   logic          out_vld;
   logic          out_rdy;
   logic [31:0]   out_data;
   logic          out_err;
   logic [1:0]    out_port;
   logic          err_clr;
   logic [15:0]   err_cnt;

   int total = 0;
   int bad   = 0;

   ecc_read_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .req_vld  (req_vld),
      .req_rdy  (req_rdy),
      .req_data (req_data),
      .req_code (req_code),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .out_err  (out_err),
      .out_port (out_port),
      .err_clr  (err_clr),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   // Check bits: XOR of Hamming positions of set data bits (data skips 1,2,4,8,..).
   function automatic logic [5:0] ham(input logic [31:0] d);
      logic [5:0] c;
      int         idx;
      c   = '0;
      idx = 0;
      for (int p = 1; p < 64; p++) begin
         if (((p & (p - 1)) != 0) && idx < 32) begin
            if (d[idx]) c = c ^ 6'(p);
            idx++;
         end
      end
      return c;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic [31:0] d, input logic [5:0] c);
      req_data[p*32 +: 32] = d;
      req_code[p*6 +: 6]   = c;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      req_vld = 4'b1111;
      reset   = 1'b1;
      step();
      total++; if (out_vld !== 1'b0)   begin bad++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      total++; if (out_err !== 1'b0)   begin bad++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
      total++; if (out_port !== 2'd0)  begin bad++; $display("FAIL reset_out_port got=%0d exp=0", out_port); end
      total++; if (err_cnt !== 16'h0)  begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
      total++; if (req_rdy !== 4'b0)   begin bad++; $display("FAIL reset_req_rdy got=%b exp=0000", req_rdy); end
      req_vld = 4'b0000;
      reset   = 1'b0;
      #1;
   endtask

   task automatic test_single_port();
      out_rdy = 1'b0;
      set_port(0, 32'h12345678, ham(32'h12345678));
      set_port(1, 32'hDEADBEEF, 6'h3F);
      req_vld = 4'b0001;
      #1;
      total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL single_req_rdy got=%b exp=0001", req_rdy); end
      step();
      req_vld = 4'b0000;
      #1;
      total++; if (out_vld !== 1'b1)          begin bad++; $display("FAIL single_out_vld got=%b exp=1", out_vld); end
      total++; if (out_data !== 32'h12345678) begin bad++; $display("FAIL single_out_data got=%h exp=12345678", out_data); end
      total++; if (out_err !== 1'b0)          begin bad++; $display("FAIL single_out_err got=%b exp=0", out_err); end
      total++; if (out_port !== 2'd0)         begin bad++; $display("FAIL single_out_port got=%0d exp=0", out_port); end
      out_rdy = 1'b1;
      step();
      total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_vld); end
   endtask

   task automatic test_round_robin();
      logic [31:0] d [4];
      logic [1:0]  exp_port [5];
      logic [3:0]  exp_rdy  [5];
      d[0] = 32'h00000011; d[1] = 32'h22220000; d[2] = 32'hCAFEF00D; d[3] = 32'h80000001;
      exp_port = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_rdy  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      for (int p = 0; p < 4; p++) set_port(p, d[p], ham(d[p]));
      out_rdy = 1'b1;
      req_vld = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++; if (req_rdy !== exp_rdy[k]) begin bad++; $display("FAIL rr_req_rdy[%0d] got=%b exp=%b", k, req_rdy, exp_rdy[k]); end
         step();
         total++; if (out_vld !== 1'b1 || out_port !== exp_port[k])
            begin bad++; $display("FAIL rr_port[%0d] got=%0d/%b exp=%0d/1", k, out_port, out_vld, exp_port[k]); end
         total++; if (out_data !== d[exp_port[k]])
            begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, out_data, d[exp_port[k]]); end
      end
      req_vld = 4'b0000;
      step();
      total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b exp=0", out_vld); end
   endtask

   // rr_ptr is 1 on entry (last grant went to port 0).
   task automatic test_backpressure();
      out_rdy = 1'b0;
      req_vld = 4'b1111;
      #1;
      total++; if (req_rdy !== 4'b0010) begin bad++; $display("FAIL bp_first_rdy got=%b exp=0010", req_rdy); end
      step();
      for (int k = 0; k < 3; k++) begin
         total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL bp_hold_rdy[%0d] got=%b exp=0000", k, req_rdy); end
         total++; if (out_vld !== 1'b1 || out_port !== 2'd1 || out_data !== 32'h22220000)
            begin bad++; $display("FAIL bp_hold_out[%0d] got=%b/%0d/%h exp=1/1/22220000", k, out_vld, out_port, out_data); end
         step();
      end
      out_rdy = 1'b1;
      #1;
      total++; if (req_rdy !== 4'b0100) begin bad++; $display("FAIL bp_release_rdy got=%b exp=0100", req_rdy); end
      step();
      total++; if (out_vld !== 1'b1 || out_port !== 2'd2 || out_data !== 32'hCAFEF00D)
         begin bad++; $display("FAIL bp_next got=%b/%0d/%h exp=1/2/cafef00d", out_vld, out_port, out_data); end
      req_vld = 4'b0000;
      step();
   endtask

   task automatic test_error();
      logic [31:0] d;
      logic [15:0] exp_cnt;
      do_reset();
      out_rdy = 1'b1;
      err_clr = 1'b0;
      d = 32'hA5A50F0F;
      set_port(0, d ^ 32'h00000020, ham(d));
      set_port(1, d, ham(d) ^ 6'h04);
      req_vld = 4'b0001;
      step();
      req_vld = 4'b0000;
`ifdef ECC_ERR_CNT_EN
      exp_cnt = 16'd1;
`else
      exp_cnt = 16'd0;
`endif
      total++; if (out_data !== d || out_err !== 1'b1)
         begin bad++; $display("FAIL err_correct got=%h/%b exp=%h/1", out_data, out_err, d); end
      total++; if (err_cnt !== exp_cnt) begin bad++; $display("FAIL err_cnt_inc got=%0d exp=%0d", err_cnt, exp_cnt); end
      // Check-bit flip on port 1 together with a clear.
      req_vld = 4'b0010;
      err_clr = 1'b1;
      step();
      req_vld = 4'b0000;
      err_clr = 1'b0;
      total++; if (out_data !== d || out_err !== 1'b1 || out_port !== 2'd1)
         begin bad++; $display("FAIL err_code_flip got=%h/%b/%0d exp=%h/1/1", out_data, out_err, out_port, d); end
      total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL err_clr_prio got=%0d exp=0", err_cnt); end
      step();
   endtask

   task automatic test_back_to_back_errors();
      logic [31:0] d [5];
      logic [15:0] exp_cnt;
      d = '{32'h00000000, 32'hFFFFFFFF, 32'h13579BDF, 32'h0F0F0F0F, 32'h8badf00d};
      out_rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_port(0, d[k] ^ (32'h1 << (k * 7)), ham(d[k]));
         req_vld = 4'b0001;
         step();
         total++; if (out_data !== d[k] || out_err !== 1'b1 || out_port !== 2'd0)
            begin bad++; $display("FAIL b2b_out[%0d] got=%h/%b/%0d exp=%h/1/0", k, out_data, out_err, out_port, d[k]); end
      end
      req_vld = 4'b0000;
`ifdef ECC_ERR_CNT_EN
      exp_cnt = 16'd5;
`else
      exp_cnt = 16'd0;
`endif
      total++; if (err_cnt !== exp_cnt) begin bad++; $display("FAIL b2b_err_cnt got=%0d exp=%0d", err_cnt, exp_cnt); end
      step();
   endtask

   task automatic test_reset_full();
      out_rdy = 1'b0;
      set_port(2, 32'h5555AAAA, ham(32'h5555AAAA));
      req_vld = 4'b0100;
      step();
      req_vld = 4'b0000;
      total++; if (out_vld !== 1'b1 || out_port !== 2'd2)
         begin bad++; $display("FAIL rf_setup got=%b/%0d exp=1/2", out_vld, out_port); end
      #2;
      reset = 1'b1;
      #1;
      total++; if (out_vld !== 1'b0 || out_data !== 32'h0 || out_port !== 2'd0)
         begin bad++; $display("FAIL rf_async got=%b/%h/%0d exp=0/0/0", out_vld, out_data, out_port); end
      step();
      reset   = 1'b0;
      out_rdy = 1'b1;
      req_vld = 4'b1111;
      #1;
      total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL rf_first_rdy got=%b exp=0001", req_rdy); end
      step();
      req_vld = 4'b0000;
      total++; if (out_vld !== 1'b1 || out_port !== 2'd0)
         begin bad++; $display("FAIL rf_first_port got=%b/%0d exp=1/0", out_vld, out_port); end
      step();
   endtask

   initial begin
      reset    = 1'b1;
      req_vld  = '0;
      req_data = '0;
      req_code = '0;
      out_rdy  = 1'b0;
      err_clr  = 1'b0;
      test_reset();
      test_single_port();
      test_round_robin();
      test_backpressure();
      test_error();
      test_back_to_back_errors();
      test_reset_full();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
